fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the control unit. Owns the fetch program counter, reads program bytes from the instruction ROM over a request/acknowledge handshake, and buffers them in a small prefetch queue. Presents the oldest byte and its address to the control unit as `datamem_data` / `datamem_address`. Accepts `jump` / `jmpaddr` redirects from the control unit, which flush all in-flight fetches.

---
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch PC, ROM handshake and prefetch queue feeding the control unit.
// Define FETCH_STALL_COUNT_EN to build the empty-queue stall counter; otherwise stall_count reads 0.
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump,
    input  logic [7:0]  jmpaddr,
    input  logic        advance,
    input  logic [7:0]  rom_data,
    input  logic        rom_ack,
    output logic        rom_req,
    output logic [7:0]  rom_addr,
    output logic [7:0]  datamem_data,
    output logic [7:0]  datamem_address,
    output logic        fetch_valid,
    output logic [15:0] stall_count
);
    localparam logic [2:0] FULL = 3'(DEPTH);

    logic [2:0] count, count_n, kept;
    logic [7:0] fetch_pc, pc_n, addr_n;
    logic       req_n, push, pop;
    logic [7:0] q_addr [DEPTH];
    logic [7:0] q_data [DEPTH];
    logic [7:0] qa_n [DEPTH];
    logic [7:0] qd_n [DEPTH];

    assign fetch_valid = count != 3'd0;

    always_comb begin
        pop = advance && fetch_valid;
        push = rom_req && rom_ack;
        kept = count - 3'(pop);
        // entry 0 is the head; a pop shifts everything down, the push lands just past the survivors
        for (int i = 0; i < DEPTH; i++) begin
            qa_n[i] = (pop && i < DEPTH - 1) ? q_addr[(i + 1) % DEPTH] : q_addr[i];
            qd_n[i] = (pop && i < DEPTH - 1) ? q_data[(i + 1) % DEPTH] : q_data[i];
            if (push && kept == 3'(i)) begin
                qa_n[i] = rom_addr;
                qd_n[i] = rom_data;
            end
        end
        count_n = jump ? 3'd0 : kept + 3'(push);
        req_n = rom_req;
        addr_n = rom_addr;
        pc_n = fetch_pc;
        if (jump) begin
            req_n = 1'b0;
            pc_n = jmpaddr;
        end else if (!rom_req || rom_ack) begin
            req_n = count_n < FULL;
            addr_n = req_n ? fetch_pc : rom_addr;
            pc_n = req_n ? fetch_pc + 8'd1 : fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 3'd0;
            fetch_pc <= 8'd0;
            rom_req <= 1'b0;
            rom_addr <= 8'd0;
            datamem_data <= 8'd0;
            datamem_address <= 8'd0;
        end else begin
            count <= count_n;
            fetch_pc <= pc_n;
            rom_req <= req_n;
            rom_addr <= addr_n;
            datamem_data <= count_n != 3'd0 ? qd_n[0] : datamem_data;
            datamem_address <= count_n != 3'd0 ? qa_n[0] : datamem_address;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            q_addr[i] <= qa_n[i];
            q_data[i] <= qd_n[i];
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= 16'd0;
        else if (!fetch_valid && stall_count != 16'hffff)
            stall_count <= stall_count + 16'd1;
    end
`else
    assign stall_count = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a ROM model returning addr^8'h5a.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jump = 1'b0;
    logic [7:0]  jmpaddr = 8'd0;
    logic        advance = 1'b0;
    logic [7:0]  rom_data;
    logic        rom_ack;
    logic        rom_req;
    logic [7:0]  rom_addr;
    logic [7:0]  datamem_data;
    logic [7:0]  datamem_address;
    logic        fetch_valid;
    logic [15:0] stall_count;
    int checks = 0;
    int errors = 0;
    int waits = 0;
    int wcnt = 0;

    fetch_unit #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .jump(jump), .jmpaddr(jmpaddr), .advance(advance),
        .rom_data(rom_data), .rom_ack(rom_ack), .rom_req(rom_req), .rom_addr(rom_addr),
        .datamem_data(datamem_data), .datamem_address(datamem_address),
        .fetch_valid(fetch_valid), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // ROM acks after `waits` idle cycles of a pending request
    assign rom_ack = rom_req && wcnt >= waits;
    assign rom_data = rom_addr ^ 8'h5a;
    always @(posedge clk) wcnt <= (reset || !rom_req || rom_ack) ? 0 : wcnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        jump = 1'b0;
        advance = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", rom_req); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", rom_addr); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fetch_valid); end
        checks++; if ({datamem_address, datamem_data} !== 16'h0000) begin errors++; $display("FAIL reset_head got %h want 0000", {datamem_address, datamem_data}); end
        checks++; if (stall_count !== 16'h0000) begin errors++; $display("FAIL reset_stall got %h want 0000", stall_count); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_stall;
        do_reset();
        waits = 0;
        advance = 1'b1;
        tick();
        checks++; if ({rom_req, rom_addr, fetch_valid} !== {1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL stream_edge1 got req=%b addr=%h v=%b want 1 00 0", rom_req, rom_addr, fetch_valid); end
        for (int k = 2; k < 9; k++) begin
            tick();
            checks++;
            if ({fetch_valid, datamem_address, datamem_data} !== {1'b1, 8'(k - 2), 8'(k - 2) ^ 8'h5a}) begin
                errors++;
                $display("FAIL stream_edge%0d got v=%b a=%h d=%h want 1 %h %h", k, fetch_valid, datamem_address, datamem_data, 8'(k - 2), 8'(k - 2) ^ 8'h5a);
            end
        end
`ifdef FETCH_STALL_COUNT_EN
        exp_stall = 16'd2;
`else
        exp_stall = 16'd0;
`endif
        checks++; if (stall_count !== exp_stall) begin errors++; $display("FAIL stream_stall got %h want %h", stall_count, exp_stall); end
        advance = 1'b0;
    endtask

    task automatic test_wait_fill();
        do_reset();
        waits = 2;
        advance = 1'b0;
        repeat (3) tick();
        checks++; if ({rom_req, rom_addr, fetch_valid} !== {1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL wait_pending got req=%b addr=%h v=%b want 1 00 0", rom_req, rom_addr, fetch_valid); end
        tick();
        checks++; if ({rom_req, rom_addr, fetch_valid, datamem_address} !== {1'b1, 8'h01, 1'b1, 8'h00}) begin errors++; $display("FAIL wait_first got req=%b addr=%h v=%b a=%h want 1 01 1 00", rom_req, rom_addr, fetch_valid, datamem_address); end
        repeat (3) tick();
        checks++; if ({rom_req, fetch_valid, datamem_address} !== {1'b0, 1'b1, 8'h00}) begin errors++; $display("FAIL wait_full got req=%b v=%b a=%h want 0 1 00", rom_req, fetch_valid, datamem_address); end
        repeat (2) tick();
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL wait_held got req=%b want 0", rom_req); end
        advance = 1'b1;
        tick();
        advance = 1'b0;
        checks++; if ({rom_req, rom_addr, datamem_address, datamem_data} !== {1'b1, 8'h02, 8'h01, 8'h5b}) begin errors++; $display("FAIL wait_refill got req=%b addr=%h a=%h d=%h want 1 02 01 5b", rom_req, rom_addr, datamem_address, datamem_data); end
    endtask

    task automatic test_jump_ack();
        do_reset();
        waits = 0;
        advance = 1'b1;
        repeat (4) tick();
        jump = 1'b1;
        jmpaddr = 8'h40;
        tick();
        jump = 1'b0;
        checks++; if ({fetch_valid, rom_req, datamem_address} !== {1'b0, 1'b0, 8'h02}) begin errors++; $display("FAIL jump_flush got v=%b req=%b a=%h want 0 0 02", fetch_valid, rom_req, datamem_address); end
        tick();
        checks++; if ({rom_req, rom_addr, fetch_valid} !== {1'b1, 8'h40, 1'b0}) begin errors++; $display("FAIL jump_req got req=%b addr=%h v=%b want 1 40 0", rom_req, rom_addr, fetch_valid); end
        tick();
        checks++; if ({fetch_valid, datamem_address, datamem_data} !== {1'b1, 8'h40, 8'h1a}) begin errors++; $display("FAIL jump_head got v=%b a=%h d=%h want 1 40 1a", fetch_valid, datamem_address, datamem_data); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a;
        waits = 0;
        advance = 1'b1;
        jump = 1'b1;
        jmpaddr = 8'hfe;
        tick();
        jump = 1'b0;
        tick();
        checks++; if ({rom_req, rom_addr} !== {1'b1, 8'hfe}) begin errors++; $display("FAIL wrap_req got req=%b addr=%h want 1 fe", rom_req, rom_addr); end
        exp_a = 8'hfe;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({fetch_valid, datamem_address, datamem_data} !== {1'b1, exp_a, exp_a ^ 8'h5a}) begin
                errors++;
                $display("FAIL wrap_%0d got v=%b a=%h d=%h want 1 %h %h", k, fetch_valid, datamem_address, datamem_data, exp_a, exp_a ^ 8'h5a);
            end
            exp_a = exp_a + 8'd1;
        end
        advance = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        waits = 2;
        advance = 1'b0;
        repeat (4) tick();
        checks++; if ({fetch_valid, rom_req, rom_addr} !== {1'b1, 1'b1, 8'h01}) begin errors++; $display("FAIL mid_setup got v=%b req=%b addr=%h want 1 1 01", fetch_valid, rom_req, rom_addr); end
        reset = 1'b1;
        tick();
        checks++;
        if ({rom_req, rom_addr, fetch_valid, datamem_address, datamem_data, stall_count} !== 34'd0) begin
            errors++;
            $display("FAIL mid_reset got req=%b addr=%h v=%b a=%h d=%h s=%h want all 0", rom_req, rom_addr, fetch_valid, datamem_address, datamem_data, stall_count);
        end
        reset = 1'b0;
        tick();
        checks++; if ({rom_req, rom_addr} !== {1'b1, 8'h00}) begin errors++; $display("FAIL mid_restart got req=%b addr=%h want 1 00", rom_req, rom_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait_fill();
        test_jump_ack();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
